// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequence controller and its bench.
package count_seq_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefLapW  = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command/counter bundle between a sequencer master and the count_seq_ctrl slave.
interface count_seq_ctrl_if
  import count_seq_pkg::*;
#(
  parameter int unsigned width = DefWidth,
  parameter int unsigned lap_w = DefLapW
);

  logic             go;
  logic             pause;
  logic             stop;
  logic [width-1:0] period;
  logic [lap_w-1:0] laps;
  logic             wrap_in;
  logic             load_o;
  logic             cnt_o;
  logic [width-1:0] start_o;
  logic [lap_w-1:0] lap_cnt;
  logic             busy;
  logic             paused;
  logic             done;
  logic             err;

  modport master (
    output go, pause, stop, period, laps, wrap_in,
    input  load_o, cnt_o, start_o, lap_cnt, busy, paused, done, err
  );

  modport slave (
    input  go, pause, stop, period, laps, wrap_in,
    output load_o, cnt_o, start_o, lap_cnt, busy, paused, done, err
  );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector; the previous sample presets to 1 so a level already high is not an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Lap sequencer for an external down-counter: loads it, counts wrap edges, supports pause/stop.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned width = DefWidth,
  parameter int unsigned lap_w = DefLapW
) (
  input logic            clk,
  input logic            rst,
  count_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [width-1:0] start_q, start_d;
  logic [lap_w-1:0] laps_q, laps_d;
  logic [lap_w-1:0] lap_cnt_q, lap_cnt_d;
  logic [lap_w-1:0] lap_inc;
  logic             load_q, load_d;
  logic             cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wrap_rise;

  rise_detect u_wrap_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.wrap_in),
    .rise_o (wrap_rise)
  );

  assign lap_inc = lap_cnt_q + lap_w'(1);

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    laps_d    = laps_q;
    lap_cnt_d = lap_cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // stop and pause outrank go even when there is nothing to stop or pause
        if (bus.go && !bus.pause && !bus.stop) begin
          if (bus.period == '0) begin
            err_d = 1'b1;
          end else begin
            start_d   = bus.period;
            laps_d    = bus.laps;
            lap_cnt_d = '0;
            state_d   = StLoad;
          end
        end
      end
      StLoad:  state_d = bus.stop ? StIdle : StRun;
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          if (wrap_rise) lap_cnt_d = lap_inc;
          // reaching the target wins over a coincident pause
          if (wrap_rise && (laps_q != '0) && (lap_inc == laps_q)) state_d = StDone;
          else if (bus.pause)                                       state_d = StPause;
        end
      end
      StPause: begin
        if (bus.stop)    state_d = StIdle;
        else if (bus.go) state_d = StRun;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    load_d   = (state_d == StLoad);
    cnt_d    = (state_d == StRun);
    busy_d   = (state_d == StLoad) || (state_d == StRun) || (state_d == StPause);
    paused_d = (state_d == StPause);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      start_q   <= '0;
      laps_q    <= '0;
      lap_cnt_q <= '0;
      load_q    <= 1'b0;
      cnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      laps_q    <= laps_d;
      lap_cnt_q <= lap_cnt_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      paused_q  <= paused_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.load_o  = load_q;
  assign bus.cnt_o   = cnt_q;
  assign bus.start_o = start_q;
  assign bus.lap_cnt = lap_cnt_q;
  assign bus.busy    = busy_q;
  assign bus.paused  = paused_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios then random commands against a behavioural model.
module tb_count_seq_ctrl;
  import count_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  count_seq_ctrl_if #(.width(DefWidth), .lap_w(DefLapW)) bus ();

  count_seq_ctrl #(.width(DefWidth), .lap_w(DefLapW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External down-counter: updates on the falling edge, reloads from start_o on wrap.
  logic [DefWidth-1:0] cnt_val = '0;
  always @(negedge clk) begin
    if (bus.load_o)     cnt_val <= bus.start_o;
    else if (bus.cnt_o) cnt_val <= (cnt_val == '0) ? bus.start_o : cnt_val - 1'b1;
  end
  assign bus.wrap_in = (cnt_val == '0);

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of the sequencer as activity flags.
  bit m_busy, m_load, m_paused, m_done, m_err, m_prev;
  int m_start, m_target, m_lap, m_total;

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_paused = 0; m_done = 0; m_err = 0; m_prev = 1;
    m_start = 0; m_target = 0; m_lap = 0;
  endtask

  task automatic model_step();
    bit lap;
    if (rst) begin
      model_reset();
      return;
    end
    lap    = bus.wrap_in && !m_prev;
    m_prev = bus.wrap_in;
    m_err  = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (bus.go && !bus.pause && !bus.stop) begin
        if (bus.period == 0) m_err = 1;
        else begin
          m_start = int'(bus.period); m_target = int'(bus.laps); m_lap = 0;
          m_busy = 1; m_load = 1;
        end
      end
    end else if (bus.stop) begin
      m_busy = 0; m_load = 0; m_paused = 0;
    end else if (m_load) begin
      m_load = 0;
    end else if (m_paused) begin
      if (bus.go) m_paused = 0;
    end else begin
      if (lap) begin
        m_lap = (m_lap + 1) % 256;
        m_total++;
        if (m_target != 0 && m_lap == m_target) begin
          m_busy = 0; m_done = 1;
        end
      end
      if (m_busy && bus.pause) m_paused = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("load_o",  32'(bus.load_o),  32'(m_load));
    chk("cnt_o",   32'(bus.cnt_o),   32'(m_busy && !m_load && !m_paused));
    chk("start_o", 32'(bus.start_o), m_start);
    chk("lap_cnt", 32'(bus.lap_cnt), m_lap);
    chk("busy",    32'(bus.busy),    32'(m_busy));
    chk("paused",  32'(bus.paused),  32'(m_paused));
    chk("done",    32'(bus.done),    32'(m_done));
    chk("err",     32'(bus.err),     32'(m_err));
  endtask

  // One rising edge: step the model, check all outputs, then drop the single-cycle commands.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.go = 0; bus.pause = 0; bus.stop = 0;
  endtask

  initial begin
    int  k;
    bit  found, seen_done, busy_drop, saw_load;
    int  base;

    bus.go = 0; bus.pause = 0; bus.stop = 0; bus.period = '0; bus.laps = '0;
    model_reset();
    m_total = 0;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Basic run: period 3, two laps
    bus.period = 16'd3; bus.laps = 8'd2; bus.go = 1;
    cycle();
    bus.period = 16'd9; bus.laps = 8'd7;
    k = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      cycle();
      if (bus.done) begin found = 1; k = i; end
    end
    chk("basic_done_edge", k, 8);
    chk("basic_lap_cnt", 32'(bus.lap_cnt), 2);
    chk("basic_cnt_off", 32'(bus.cnt_o), 0);
    chk("basic_start", 32'(bus.start_o), 3);
    cycle();

    // Zero period is rejected
    bus.period = 16'd0; bus.laps = 8'd1; bus.go = 1;
    cycle();
    chk("zero_err", 32'(bus.err), 1);
    chk("zero_busy", 32'(bus.busy), 0);
    saw_load = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.load_o) saw_load = 1;
    end
    chk("zero_no_load", 32'(saw_load), 0);

    // Pause after two counts, hold 10 cycles, resume
    bus.period = 16'd5; bus.laps = 8'd1; bus.go = 1;
    cycle();
    cycle();
    cycle();
    bus.pause = 1;
    cycle();
    chk("pr_paused", 32'(bus.paused), 1);
    repeat (10) cycle();
    chk("pr_no_lap", 32'(bus.lap_cnt), 0);
    bus.go = 1;
    cycle();
    k = 0; found = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      cycle();
      if (bus.done) begin found = 1; k = i; end
    end
    chk("pr_done_after_resume", k, 3);
    cycle();

    // stop + pause + go together in RUN
    bus.period = 16'd4; bus.laps = 8'd0; bus.go = 1;
    cycle();
    cycle();
    cycle();
    bus.stop = 1; bus.pause = 1; bus.go = 1;
    cycle();
    chk("sim_busy", 32'(bus.busy), 0);
    chk("sim_done", 32'(bus.done), 0);
    cycle();

    // Pause coinciding with the first wrap edge
    bus.period = 16'd2; bus.laps = 8'd0; bus.go = 1;
    cycle();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.wrap_in && bus.cnt_o) found = 1;
      else cycle();
    end
    chk("pw_wrap_found", 32'(found), 1);
    bus.pause = 1;
    cycle();
    chk("pw_lap_cnt", 32'(bus.lap_cnt), 1);
    chk("pw_paused", 32'(bus.paused), 1);
    bus.stop = 1;
    cycle();

    // Free run: 300 laps of period 1
    bus.period = 16'd1; bus.laps = 8'd0; bus.go = 1;
    cycle();
    base = m_total; seen_done = 0; busy_drop = 0;
    for (int i = 0; i < 1000 && (m_total - base) < 300; i++) begin
      cycle();
      if (bus.done) seen_done = 1;
      if (!bus.busy) busy_drop = 1;
    end
    chk("free_laps_reached", m_total - base, 300);
    chk("free_lap_cnt", 32'(bus.lap_cnt), 44);
    chk("free_no_done", 32'(seen_done), 0);
    chk("free_busy_held", 32'(busy_drop), 0);
    bus.stop = 1;
    cycle();

    // Asynchronous reset mid-run at lap 3
    bus.period = 16'd2; bus.laps = 8'd0; bus.go = 1;
    cycle();
    for (int i = 0; i < 50 && m_lap != 3; i++) cycle();
    chk("rst_at_lap3", 32'(bus.lap_cnt), 3);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all();
    chk("rst_async_busy", 32'(bus.busy), 0);
    cycle();
    rst = 0;
    cycle();
    bus.period = 16'd2; bus.laps = 8'd1; bus.go = 1;
    cycle();
    chk("restart_lap", 32'(bus.lap_cnt), 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.done) found = 1;
    end
    chk("restart_done", 32'(found), 1);
    cycle();

    // Random commands
    for (int i = 0; i < 1500; i++) begin
      bus.go     = ($urandom_range(0, 5) == 0);
      bus.pause  = ($urandom_range(0, 9) == 0);
      bus.stop   = ($urandom_range(0, 29) == 0);
      bus.period = 16'($urandom_range(0, 4));
      bus.laps   = 8'($urandom_range(0, 3));
      if (rst) begin
        rst = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1;
        model_reset();
        #1;
        check_all();
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
